// File: rtl/i2c_wb_slave.sv
// I2C slave with a Wishbone register front end: CSR, slave address, transmit and receive bytes.
// A single always_ff holds all state; hardware status sets are written after bus writes so set wins over w1c.
module i2c_wb_slave #(
  parameter int         WB_ADDR_WIDTH  = 2,
  parameter int         WB_DATA_WIDTH  = 8,
  parameter int         I2C_DATA_WIDTH = 8,
  parameter logic [6:0] RESET_SLV_ADDR = 7'h22
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cyc_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  output logic                     ack_o,
  output logic                     irq_o,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_o
);

  localparam int DW  = WB_DATA_WIDTH;
  localparam int IDW = I2C_DATA_WIDTH;
  localparam logic [WB_ADDR_WIDTH-1:0] A_CSR = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] A_ADR = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_TXD = WB_ADDR_WIDTH'(2);
  localparam logic [WB_ADDR_WIDTH-1:0] A_RXD = WB_ADDR_WIDTH'(3);
  // bit_cnt reaches IDW after the last data bit, IDW+1 once the ACK clock is under way
  localparam logic [3:0] LAST_BIT  = 4'(IDW - 1);
  localparam logic [3:0] ACK_DRIVE = 4'(IDW);
  localparam logic [3:0] ACK_DONE  = 4'(IDW + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t           state;
  logic             en, ie, busy, rxv, txe, ovr, stp, irqp;
  logic [6:0]       slv_adr;
  logic [IDW-1:0]   txd, rxd, shift, tx_shift;
  logic [3:0]       bit_cnt;
  logic             rw, addressed;
  logic [1:0]       scl_sync, sda_sync;
  logic             scl_q, sda_q;
  logic             scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic             wb_hit;
  logic [IDW-1:0]   rx_byte, tx_load;
  logic [DW-1:0]    rd_val;

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign wb_hit    = cyc_i & stb_i & ~ack_o;
  assign rx_byte   = {shift[IDW-2:0], sda_s};
  // an empty transmit register goes out as all ones so the master sees an idle line
  assign tx_load   = txe ? '1 : txd;

  always_comb begin
    rd_val = '0;
    case (adr_i)
      A_CSR:   rd_val = DW'({en, ie, busy, rxv, txe, ovr, stp, irqp});
      A_ADR:   rd_val = DW'({1'b0, slv_adr});
      A_TXD:   rd_val = DW'(txd);
      A_RXD:   rd_val = DW'(rxd);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      {en, ie, busy, rxv, ovr, stp, irqp} <= '0;
      txe       <= 1'b1;
      slv_adr   <= RESET_SLV_ADDR;
      txd       <= '0;
      rxd       <= '0;
      shift     <= '0;
      tx_shift  <= '0;
      bit_cnt   <= '0;
      rw        <= 1'b0;
      addressed <= 1'b0;
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      sda_o     <= 1'b1;
      ack_o     <= 1'b0;
      dat_o     <= '0;
      irq_o     <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
      ack_o    <= wb_hit;
      irq_o    <= ie & irqp;

      if (wb_hit) begin
        if (we_i) begin
          case (adr_i)
            A_CSR: begin
              en <= dat_i[7];
              ie <= dat_i[6];
              if (dat_i[2]) ovr  <= 1'b0;
              if (dat_i[1]) stp  <= 1'b0;
              if (dat_i[0]) irqp <= 1'b0;
            end
            A_ADR: slv_adr <= dat_i[6:0];
            A_TXD: begin
              txd <= dat_i[IDW-1:0];
              txe <= 1'b0;
            end
            default: ;
          endcase
        end else begin
          dat_o <= rd_val;
          if (adr_i == A_RXD) rxv <= 1'b0;
        end
      end

      if (stop_det) begin
        state     <= IDLE;
        sda_o     <= 1'b1;
        busy      <= 1'b0;
        addressed <= 1'b0;
        if (addressed) begin
          stp  <= 1'b1;
          irqp <= 1'b1;
        end
      end else if (start_det && en) begin
        state   <= ADDR;
        bit_cnt <= '0;
        busy    <= 1'b1;
        sda_o   <= 1'b1;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              if (rx_byte[7:1] == slv_adr) begin
                state     <= ADDR_ACK;
                rw        <= rx_byte[0];
                addressed <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            if (bit_cnt == ACK_DRIVE) begin
              sda_o   <= 1'b0;
              bit_cnt <= ACK_DONE;
            end else begin
              bit_cnt <= '0;
              if (state == ADDR_ACK && rw) begin
                state    <= RD_DATA;
                sda_o    <= tx_load[IDW-1];
                tx_shift <= tx_load << 1;
              end else begin
                state <= WR_DATA;
                sda_o <= 1'b1;
              end
            end
          end
          WR_DATA: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              rxd   <= rx_byte;
              if (rxv) ovr <= 1'b1;
              rxv   <= 1'b1;
              irqp  <= 1'b1;
              state <= WR_ACK;
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) txe <= 1'b1;
            end
            if (scl_fall) begin
              if (bit_cnt == ACK_DRIVE) begin
                sda_o <= 1'b1;
                state <= RD_ACK;
              end else begin
                sda_o    <= tx_shift[IDW-1];
                tx_shift <= tx_shift << 1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) state <= IGNORE;
              else bit_cnt <= ACK_DONE;
            end
            if (scl_fall && bit_cnt == ACK_DONE) begin
              state    <= RD_DATA;
              bit_cnt  <= '0;
              sda_o    <= tx_load[IDW-1];
              tx_shift <= tx_load << 1;
            end
          end
          default: sda_o <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_wb_slave.sv
// Bench for i2c_wb_slave: a bit-banged I2C master plus Wishbone register accesses.
// Register reads are scored against a queue of expected values by a separate monitor.
module tb_i2c_wb_slave;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] dat_w, dat_r;
  logic       ack, irq, sda_o;
  logic       scl_m, sda_m;
  logic       sda_bus;

  int         checks = 0;
  int         failures = 0;
  string      name_q[$];
  logic [7:0] exp_q[$];
  string      mon_name;
  logic [7:0] mon_exp;

  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_wb_slave dut (
    .clk_i (clk),
    .rst_i (rst),
    .cyc_i (cyc),
    .stb_i (stb),
    .we_i  (we),
    .adr_i (adr),
    .dat_i (dat_w),
    .dat_o (dat_r),
    .ack_o (ack),
    .irq_o (irq),
    .scl_i (scl_m),
    .sda_i (sda_bus),
    .sda_o (sda_o)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read monitor: every acknowledged read consumes the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && ack && !we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_read: got %0h expected none", dat_r);
      end else begin
        mon_name = name_q.pop_front();
        mon_exp  = exp_q.pop_front();
        check_output(mon_name, 32'(dat_r), 32'(mon_exp));
      end
    end
  end

  task automatic wb_access(input logic w, input logic [1:0] a, input logic [7:0] d);
    int cnt;
    string dn;
    logic [7:0] de;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    cnt = 0;
    while (cnt < 8) begin
      @(posedge clk); #1;
      cnt++;
      if (ack) break;
    end
    check_output("ack_latency", 32'(cnt), 1);
    if (!ack && !w && exp_q.size() > 0) begin
      dn = name_q.pop_back();
      de = exp_q.pop_back();
    end
    @(negedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check_output("ack_one_cycle", 32'(ack), 0);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    wb_access(1'b1, a, d);
  endtask

  task automatic wb_read(input logic [1:0] a, input logic [7:0] e, input string n);
    name_q.push_back(n);
    exp_q.push_back(e);
    wb_access(1'b0, a, 8'h00);
  endtask

  task automatic wait_q;
    repeat (Q) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_q;
    scl_m = 1'b1; wait_q;
    sda_m = 1'b0; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_q;
    scl_m = 1'b1; wait_q;
    sda_m = 1'b1; wait_q;
  endtask

  task automatic i2c_bit(input logic b, output logic obs);
    sda_m = b;    wait_q;
    scl_m = 1'b1; wait_q;
    obs = sda_bus;
    wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic i2c_write_byte(input logic [7:0] b, output logic ack_bit);
    logic dummy;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], dummy);
    i2c_bit(1'b1, ack_bit);
  endtask

  task automatic i2c_read_byte(input logic master_ack, output logic [7:0] b);
    logic o;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, o);
      b[i] = o;
    end
    i2c_bit(master_ack, o);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       a;
    logic [7:0] rb;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_w = 8'h00;
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_output("rst_sda", 32'(sda_o), 1);
    check_output("rst_ack", 32'(ack), 0);
    check_output("rst_dat", 32'(dat_r), 0);
    check_output("rst_irq", 32'(irq), 0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    wb_read(2'd0, 8'h08, "rst_csr");
    wb_read(2'd1, 8'h22, "rst_adr");
    wb_read(2'd2, 8'h00, "rst_txd");
    wb_read(2'd3, 8'h00, "rst_rxd");

    // register access basics, ADR[7] never stored
    wb_write(2'd0, 8'hC0);
    wb_read(2'd0, 8'hC8, "csr_en_ie");
    wb_read(2'd1, 8'h22, "adr_default");
    wb_write(2'd1, 8'h85);
    wb_read(2'd1, 8'h05, "adr_bit7_zero");
    wb_write(2'd1, 8'h22);

    // master write of one byte to our address
    i2c_start;
    i2c_write_byte(8'h44, a);
    check_output("wr_addr_ack", 32'(a), 0);
    wb_read(2'd0, 8'hE8, "csr_busy");
    i2c_write_byte(8'hA5, a);
    check_output("wr_data_ack", 32'(a), 0);
    i2c_stop;
    repeat (4) @(posedge clk); #1;
    check_output("irq_after_write", 32'(irq), 1);
    wb_read(2'd0, 8'hDB, "csr_after_write");
    wb_read(2'd3, 8'hA5, "rxd_a5");
    wb_read(2'd0, 8'hCB, "csr_rxv_cleared");
    wb_write(2'd0, 8'hC3);
    wb_read(2'd0, 8'hC8, "csr_w1c");
    check_output("irq_cleared", 32'(irq), 0);

    // master read with NACK
    wb_write(2'd2, 8'h3C);
    wb_read(2'd0, 8'hC0, "csr_txe_clear");
    wb_read(2'd2, 8'h3C, "txd_readback");
    i2c_start;
    i2c_write_byte(8'h45, a);
    check_output("rd_addr_ack", 32'(a), 0);
    i2c_read_byte(1'b1, rb);
    check_output("rd_bus_byte", 32'(rb), 32'h3C);
    i2c_stop;
    wb_read(2'd0, 8'hCB, "csr_after_read");
    check_output("irq_after_read", 32'(irq), 1);
    wb_write(2'd0, 8'hC3);
    wb_read(2'd0, 8'hC8, "csr_w1c_read");

    // foreign address is ignored, then our address is still recognised
    i2c_start;
    i2c_write_byte(8'h46, a);
    check_output("foreign_addr_nack", 32'(a), 1);
    i2c_write_byte(8'h55, a);
    check_output("foreign_data_nack", 32'(a), 1);
    i2c_stop;
    wb_read(2'd0, 8'hC8, "csr_after_foreign");
    wb_read(2'd3, 8'hA5, "rxd_unchanged");
    i2c_start;
    i2c_write_byte(8'h44, a);
    check_output("readdress_ack", 32'(a), 0);
    i2c_stop;
    wb_read(2'd0, 8'hCB, "csr_after_readdress");
    wb_write(2'd0, 8'hC3);

    // two bytes without an RXD read overrun
    i2c_start;
    i2c_write_byte(8'h44, a);
    check_output("ovr_addr_ack", 32'(a), 0);
    i2c_write_byte(8'h11, a);
    check_output("ovr_byte1_ack", 32'(a), 0);
    i2c_write_byte(8'h99, a);
    check_output("ovr_byte2_ack", 32'(a), 0);
    i2c_stop;
    wb_read(2'd0, 8'hDF, "csr_overrun");
    wb_read(2'd3, 8'h99, "rxd_second");
    wb_write(2'd0, 8'h07);
    wb_read(2'd0, 8'h08, "csr_w1c_all");
    check_output("irq_disabled", 32'(irq), 0);

    // disabled slave ignores START
    i2c_start;
    i2c_write_byte(8'h44, a);
    check_output("disabled_nack", 32'(a), 1);
    i2c_stop;
    wb_read(2'd0, 8'h08, "csr_disabled");

    // reset while the slave is pulling SDA low during a read
    wb_write(2'd0, 8'h80);
    wb_write(2'd1, 8'h31);
    wb_write(2'd2, 8'h7F);
    i2c_start;
    i2c_write_byte(8'h63, a);
    check_output("mid_rd_addr_ack", 32'(a), 0);
    check_output("rd_bit7_low", 32'(sda_o), 0);
    #1 rst = 1'b1;
    #1 check_output("rst_async_sda", 32'(sda_o), 1);
    repeat (2) @(posedge clk);
    i2c_stop;
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    wb_read(2'd0, 8'h08, "post_rst_csr");
    wb_read(2'd1, 8'h22, "post_rst_adr");
    wb_read(2'd2, 8'h00, "post_rst_txd");
    wb_read(2'd3, 8'h00, "post_rst_rxd");
    check_output("post_rst_irq", 32'(irq), 0);

    repeat (4) @(posedge clk);
    check_output("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
